// File: rtl/shift_chain_ctrl_if.sv
// rtl/shift_chain_ctrl_if.sv - command handshake bundle for the shift chain sequencer
interface shift_chain_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_count,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_count,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/shift_chain_ctrl.sv
// rtl/shift_chain_ctrl.sv - clear/load/multi-step shift sequencer for a WIDTH-bit chain register
module shift_chain_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    shift_chain_ctrl_if.slave       cmd,
    input  logic                    fill_in,
    output logic [WIDTH-1:0]        chain_q,
    output logic                    busy,
    output logic                    shift_en,
    output logic                    dir,
    output logic                    done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_SHL   = 2'b10;
    localparam logic [1:0] OP_SHR   = 2'b11;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] remaining;
    logic             accept;
    logic             count_zero;
    logic             last_shift;

    // Only flush reaches cmd_ready combinationally; everything else is state decode.
    assign cmd.cmd_ready = (state == S_IDLE) & ~flush;
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    assign count_zero    = (cmd.cmd_count == '0);
    assign last_shift    = (remaining == {{(CNT_W-1){1'b0}}, 1'b1});

    assign busy     = (state == S_SHIFT) | (state == S_DONE);
    assign shift_en = (state == S_SHIFT);
    assign done     = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if ((cmd.cmd_op == OP_SHL || cmd.cmd_op == OP_SHR) && !count_zero) begin
                            next_state = S_SHIFT;
                        end else begin
                            next_state = S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    if (last_shift) begin
                        next_state = S_DONE;
                    end
                end
                S_DONE: begin
                    next_state = S_IDLE;
                end
                default: begin
                    next_state = S_IDLE;
                end
            endcase
        end
    end

    // Chain, remaining count and direction; flush wins over any command or shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q   <= '0;
            remaining <= '0;
            dir       <= 1'b0;
        end else if (flush) begin
            chain_q   <= '0;
            remaining <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (cmd.cmd_op)
                            OP_CLEAR: chain_q <= '0;
                            OP_LOAD:  chain_q <= cmd.cmd_data;
                            default: begin
                                remaining <= cmd.cmd_count;
                                dir       <= cmd.cmd_op[0];
                            end
                        endcase
                    end
                end
                S_SHIFT: begin
                    if (dir) begin
                        chain_q <= {fill_in, chain_q[WIDTH-1:1]};
                    end else begin
                        chain_q <= {chain_q[WIDTH-2:0], fill_in};
                    end
                    remaining <= remaining - 1'b1;
                end
                default: begin
                    remaining <= remaining;
                end
            endcase
        end
    end

endmodule

// File: doc/shift_chain_ctrl.md
# shift_chain_ctrl

Sequencer for the bidirectional hold/shift/clear register chain used across the shift-chain benchmarks. It owns a WIDTH-bit chain register and drives it from a command interface with a valid/ready handshake. Supported commands are clear, parallel load, and multi-step shift left or right with a serial fill bit. The block sits between the host-side command source and the chain consumer, and reports completion with a one-cycle done pulse.

## Interface
- WIDTH, default 16: chain length in bits; minimum 2.
- CNT_W, default 5: width of the shift-count field; maximum count is 2^CNT_W-1.

- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort; highest priority.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block accepts a command this cycle.
- cmd_op  input  2  00 CLEAR, 01 LOAD, 10 SHL, 11 SHR.
- cmd_count  input  CNT_W  number of single-bit shifts (SHL/SHR only).
- cmd_data  input  WIDTH  load value (LOAD only).
- fill_in  input  1  serial bit inserted on each shift; sampled every shift cycle, not latched at accept.
- chain_q  output  WIDTH  current chain contents (registered).
- busy  output  1  high in SHIFT and DONE states.
- shift_en  output  1  a shift occurs at the end of this cycle.
- dir  output  1  direction of the active or last shift: 0 left, 1 right.
- done  output  1  one-cycle pulse; the result of the completed command is valid on chain_q in this cycle.

## Operation
- States:
  - IDLE: cmd_ready=1.
  - SHIFT: remaining count > 0.
  - DONE: lasts one cycle; done=1, cmd_ready=0.
- cmd_ready = (state==IDLE) & ~flush. A command is accepted when cmd_valid & cmd_ready.
- Accept CLEAR: chain_q <= 0; go to DONE.
- Accept LOAD: chain_q <= cmd_data; go to DONE.
- Accept SHL/SHR with cmd_count=0:
  - chain unchanged; go to DONE.
  - dir <= op[0].
- Accept SHL/SHR with cmd_count=n>0:
  - remaining <= n; dir <= op[0]; go to SHIFT.
  - No shift happens in the accept cycle.
- In SHIFT:
  - shift_en=1.
  - SHL: chain_q <= {chain_q[WIDTH-2:0], fill_in}.
  - SHR: chain_q <= {fill_in, chain_q[WIDTH-1:1]}.
  - remaining decrements each cycle. When remaining==1, this is the last shift; next state is DONE.
- DONE always returns to IDLE. The next command can be accepted the cycle after done.
- flush in any state:
  - chain_q <= 0, remaining <= 0, state <= IDLE.
  - No done pulse; any in-progress command is discarded.
  - A cmd_valid in the same cycle is not accepted.
- cmd_valid while not ready: the command is ignored. The source must hold it; the block does not queue.
- Shift count n > WIDTH is legal. The chain is filled entirely with fill_in history.
- cmd_op, cmd_count and cmd_data are only sampled at accept. fill_in is sampled in each SHIFT cycle.

## Timing
- Reset values (asynchronous, rst_n=0):
  - chain_q=0, state=IDLE, remaining=0, dir=0.
  - done=0, busy=0, shift_en=0, cmd_ready=1 (when flush=0).
- Reset asserted mid-command: the block returns immediately to reset values; no done pulse.
- Accept at cycle T:
  - CLEAR, LOAD, or count 0: chain_q updated (if applicable) at the T edge; done=1 in T+1; cmd_ready=1 in T+2.
  - SHL/SHR with count n>0: shifts happen at the ends of cycles T+1..T+n; shift_en=1 and busy=1 in T+1..T+n.
  - Shift completion: done=1 and busy=1 in T+n+1, with the final chain value on chain_q; cmd_ready=1 in T+n+2.
- Throughput: one command per n+2 cycles (2 cycles for n=0, CLEAR, LOAD).
- done, busy, shift_en and cmd_ready are decoded from registered state only; there is no input-to-output combinational path except flush on cmd_ready.

## Test plan
- Reset and load (WIDTH=8):
  - Reset -> chain_q=0x00, cmd_ready=1.
  - LOAD 0xA5 accepted at T -> chain_q=0xA5 and done=1 at T+1; cmd_ready=1 at T+2.
- SHL 3, fill_in=1, from 0xA5 -> chain_q 0x4B, 0x97, 0x2F over T+2..T+4 (after the shifts at the ends of T+1..T+3); done=1 at T+4; shift_en high exactly 3 cycles.
- SHR 2, fill_in=0, from 0x2F -> 0x17 then 0x0B; dir=1; done after 2 shift cycles.
- SHL 0 -> chain unchanged; done at T+1; shift_en never asserted. CLEAR -> chain_q=0x00, done at T+1.
- flush during SHL 10 after 4 shifts -> chain_q=0x00 next cycle; no done pulse; cmd_ready=1 next cycle. A cmd_valid held during busy is accepted only after IDLE.
- rst_n dropped mid-SHR 5 -> all outputs at reset values immediately. After release, LOAD 0xFF completes normally.
